// File: rtl/alu_arbiter.sv
// Two-client round-robin front end for one shared combinational ALU.
// Each operation is sequenced IDLE -> ISSUE -> RESP with registered operands and response.
module alu_arbiter #(
    parameter int BITS_SIZE  = 32,
    parameter int CNTRL_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [BITS_SIZE-1:0]  req0_a,
    input  logic [BITS_SIZE-1:0]  req0_b,
    input  logic [CNTRL_SIZE-1:0] req0_op,
    input  logic                  req0_cin,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [BITS_SIZE-1:0]  req1_a,
    input  logic [BITS_SIZE-1:0]  req1_b,
    input  logic [CNTRL_SIZE-1:0] req1_op,
    input  logic                  req1_cin,

    output logic [BITS_SIZE-1:0]  alu_a,
    output logic [BITS_SIZE-1:0]  alu_b,
    output logic [CNTRL_SIZE-1:0] alu_cntrl,
    output logic                  alu_cin,
    input  logic [BITS_SIZE-1:0]  alu_out,
    input  logic                  alu_zero,
    input  logic                  alu_ovf,
    input  logic                  alu_neg,
    input  logic                  alu_carry,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [BITS_SIZE-1:0]  resp_result,
    output logic                  resp_zero,
    output logic                  resp_ovf,
    output logic                  resp_neg,
    output logic                  resp_carry,
    output logic                  resp_err,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [CNTRL_SIZE-1:0] OP_ILLEGAL_MIN = CNTRL_SIZE'(14);

    state_e                  state_q;
    logic                    last_id_q;
    logic [BITS_SIZE-1:0]    alu_a_q;
    logic [BITS_SIZE-1:0]    alu_b_q;
    logic [CNTRL_SIZE-1:0]   alu_cntrl_q;
    logic                    alu_cin_q;
    logic                    resp_valid_q;
    logic                    resp_id_q;
    logic [BITS_SIZE-1:0]    resp_result_q;
    logic                    resp_zero_q;
    logic                    resp_ovf_q;
    logic                    resp_neg_q;
    logic                    resp_carry_q;
    logic                    resp_err_q;
    logic [15:0]             op_count_q;

    logic                    grant_d;
    logic                    accept_d;
    logic [BITS_SIZE-1:0]    sel_a_d;
    logic [BITS_SIZE-1:0]    sel_b_d;
    logic [CNTRL_SIZE-1:0]   sel_op_d;
    logic                    sel_cin_d;
    logic                    op_illegal;

    // Grant goes to the client that did not win last time when both are asking.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        grant_d = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_d = ~last_id_q;
        end else if (req1_valid) begin
            grant_d = 1'b1;
        end
        req0_ready = (state_q == IDLE) && req0_valid && !grant_d;
        req1_ready = (state_q == IDLE) && req1_valid &&  grant_d;
        accept_d   = req0_ready || req1_ready;
    end

    always_comb begin
        sel_a_d   = req0_a;
        sel_b_d   = req0_b;
        sel_op_d  = req0_op;
        sel_cin_d = req0_cin;
        if (grant_d) begin
            sel_a_d   = req1_a;
            sel_b_d   = req1_b;
            sel_op_d  = req1_op;
            sel_cin_d = req1_cin;
        end
    end

    assign op_illegal = (alu_cntrl_q >= OP_ILLEGAL_MIN);

    // The alu_* registers double as the captured request; they only change on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_id_q     <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_cntrl_q   <= '0;
            alu_cin_q     <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_ovf_q    <= 1'b0;
            resp_neg_q    <= 1'b0;
            resp_carry_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            op_count_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        alu_a_q     <= sel_a_d;
                        alu_b_q     <= sel_b_d;
                        alu_cntrl_q <= sel_op_d;
                        alu_cin_q   <= sel_cin_d;
                        last_id_q   <= grant_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    resp_id_q    <= last_id_q;
                    resp_err_q   <= op_illegal;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                    if (op_illegal) begin
                        // ALU outputs are undefined for these codes; never let them through.
                        resp_result_q <= '0;
                        resp_zero_q   <= 1'b0;
                        resp_ovf_q    <= 1'b0;
                        resp_neg_q    <= 1'b0;
                        resp_carry_q  <= 1'b0;
                    end else begin
                        resp_result_q <= alu_out;
                        resp_zero_q   <= alu_zero;
                        resp_ovf_q    <= alu_ovf;
                        resp_neg_q    <= alu_neg;
                        resp_carry_q  <= alu_carry;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        op_count_q   <= op_count_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_cntrl   = alu_cntrl_q;
    assign alu_cin     = alu_cin_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_ovf    = resp_ovf_q;
    assign resp_neg    = resp_neg_q;
    assign resp_carry  = resp_carry_q;
    assign resp_err    = resp_err_q;
    assign op_count    = op_count_q;

    a_single_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));

    a_resp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_result) && $stable(resp_id)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized two-client traffic
// against a transaction-level model; a behavioural ALU stands in for the shared datapath.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_cin;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_op;
    logic        req1_valid, req1_ready, req1_cin;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_cntrl;
    logic        alu_cin, alu_zero, alu_ovf, alu_neg, alu_carry;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_result;
    logic        resp_zero, resp_ovf, resp_neg, resp_carry, resp_err;
    logic [15:0] op_count;

    int          checks   = 0;
    int          failures = 0;
    logic        m_last;
    logic [15:0] exp_count;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        neg;
        logic        carry;
    } alu_res_t;

    typedef struct packed {
        logic     id;
        logic     err;
        alu_res_t r;
    } resp_t;

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        cin;
    } req_t;

    alu_res_t stub_r;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_neg(alu_neg),
        .alu_carry(alu_carry),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_ovf(resp_ovf),
        .resp_neg(resp_neg), .resp_carry(resp_carry), .resp_err(resp_err),
        .op_count(op_count)
    );

    // Behavioural ALU: AND, OR, XOR, ADD (with carry-in), SUB (carry = borrow), else ~a.
    function automatic alu_res_t alu_golden(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic cin);
        alu_res_t    r;
        logic [32:0] wide;
        r    = '0;
        wide = '0;
        case (op)
            4'b0000: r.result = a & b;
            4'b0001: r.result = a | b;
            4'b0010: r.result = a ^ b;
            4'b0101: begin
                wide     = {1'b0, a} + {1'b0, b} + {32'b0, cin};
                r.result = wide[31:0];
                r.carry  = wide[32];
                r.ovf    = (a[31] == b[31]) && (r.result[31] != a[31]);
            end
            4'b0111: begin
                wide     = {1'b0, a} - {1'b0, b};
                r.result = wide[31:0];
                r.carry  = wide[32];
                r.ovf    = (a[31] != b[31]) && (r.result[31] != a[31]);
            end
            default: r.result = ~a;
        endcase
        r.zero = (r.result == 32'd0);
        r.neg  = r.result[31];
        return r;
    endfunction

    // Illegal codes make the stub produce garbage the arbiter must suppress.
    always_comb begin
        stub_r = alu_golden(alu_a, alu_b, alu_cntrl, alu_cin);
        if (alu_cntrl >= 4'b1110) stub_r = {32'hDEADBEEF, 4'b1111};
        {alu_out, alu_zero, alu_ovf, alu_neg, alu_carry} = stub_r;
    end

    function automatic resp_t expect_resp(input req_t q);
        resp_t e;
        e.id = q.id;
        if (q.op >= 4'b1110) begin
            e.err = 1'b1;
            e.r   = '0;
        end else begin
            e.err = 1'b0;
            e.r   = alu_golden(q.a, q.b, q.op, q.cin);
        end
        return e;
    endfunction

    function automatic resp_t get_resp();
        return {resp_id, resp_err, resp_result, resp_zero, resp_ovf, resp_neg, resp_carry};
    endfunction

    function automatic req_t rand_req(input logic id);
        req_t q;
        int   s;
        q.id  = id;
        q.a   = $urandom;
        q.b   = $urandom;
        q.cin = 1'($urandom_range(1));
        s     = $urandom_range(9);
        case (s)
            0:       q.op = 4'b0000;
            1:       q.op = 4'b0001;
            2:       q.op = 4'b0010;
            3, 4:    q.op = 4'b0101;
            5, 6:    q.op = 4'b0111;
            7:       q.op = 4'b0011;
            8:       q.op = 4'b1110;
            default: q.op = 4'b1111;
        endcase
        if ($urandom_range(3) == 0) q.b = q.a;
        if ($urandom_range(3) == 0) q.a = 32'h7FFFFFFF;
        return q;
    endfunction

    task automatic drive_req(input int k, input req_t q);
        if (k == 0) begin
            req0_a = q.a; req0_b = q.b; req0_op = q.op; req0_cin = q.cin;
        end else begin
            req1_a = q.a; req1_b = q.b; req1_op = q.op; req1_cin = q.cin;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        m_last    = 1'b1;
        exp_count = 16'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (get_resp() !== 38'd0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_resp got=%h valid=%b exp=0", get_resp(), resp_valid);
        end
        checks++;
        if ({alu_a, alu_b, alu_cntrl, alu_cin} !== 69'd0 || op_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_alu_cnt got=%h/%h/%h/%b cnt=%h exp=0", alu_a, alu_b, alu_cntrl, alu_cin, op_count);
        end
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready_idle got=%b exp=00", {req1_ready, req0_ready});
        end
        req0_valid = 1'b1; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_ready_r0 got=%b exp=01", {req1_ready, req0_ready});
        end
        req1_valid = 1'b1; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_first_tie got=%b exp=01", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            failures++;
            $display("FAIL reset_ready_r1 got=%b exp=10", {req1_ready, req0_ready});
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_single_add();
        req_t  q;
        resp_t e;
        q = '{id: 1'b0, a: 32'h7FFFFFFF, b: 32'd1, op: 4'b0101, cin: 1'b0};
        e = {1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        drive_req(0, q); req0_valid = 1'b1; resp_ready = 1'b1; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL add_accept got=%b exp=01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0; #1;
        checks++;
        if (resp_valid !== 1'b0 || {alu_a, alu_b, alu_cntrl, alu_cin} !== {q.a, q.b, q.op, q.cin}) begin
            failures++;
            $display("FAIL add_issue valid=%b alu=%h/%h/%h/%b exp valid=0 alu=%h/%h/%h/%b",
                     resp_valid, alu_a, alu_b, alu_cntrl, alu_cin, q.a, q.b, q.op, q.cin);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || get_resp() !== e) begin
            failures++;
            $display("FAIL add_resp valid=%b got=%h exp=%h", resp_valid, get_resp(), e);
        end
        m_last = 1'b0;
        exp_count++;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || op_count !== exp_count) begin
            failures++;
            $display("FAIL add_done valid=%b cnt=%h exp valid=0 cnt=%h", resp_valid, op_count, exp_count);
        end
    endtask

    // Randomized traffic against a transaction-level model of grant order, latency and results.
    task automatic test_traffic(input string name, input int n_ops, input int p_valid,
                                input int p_ready, input bit check_alt);
        req_t       pend [2];
        logic       v [2];
        req_t       cur;
        resp_t      e;
        logic [1:0] exp_rdy;
        bit         busy;
        int         acc_cyc, done, grants, k;
        busy = 0; acc_cyc = 0; done = 0; grants = 0;
        v[0] = 1'b0; v[1] = 1'b0;
        pend[0] = rand_req(1'b0);
        pend[1] = rand_req(1'b1);
        cur = pend[0];
        e   = '0;
        for (int cyc = 0; cyc < n_ops * 40 + 100 && done < n_ops; cyc++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== (busy && (cyc - acc_cyc >= 2))) begin
                failures++;
                $display("FAIL %s_resp_valid cyc=%0d got=%b exp=%b", name, cyc, resp_valid, busy && (cyc - acc_cyc >= 2));
            end
            checks++;
            if (op_count !== exp_count) begin
                failures++;
                $display("FAIL %s_op_count cyc=%0d got=%h exp=%h", name, cyc, op_count, exp_count);
            end
            if (busy && cyc - acc_cyc == 1) begin
                checks++;
                if ({alu_a, alu_b, alu_cntrl, alu_cin} !== {cur.a, cur.b, cur.op, cur.cin}) begin
                    failures++;
                    $display("FAIL %s_alu_drive got=%h/%h/%h/%b exp=%h/%h/%h/%b", name,
                             alu_a, alu_b, alu_cntrl, alu_cin, cur.a, cur.b, cur.op, cur.cin);
                end
            end
            if (busy && cyc - acc_cyc >= 2) begin
                checks++;
                if (get_resp() !== e) begin
                    failures++;
                    $display("FAIL %s_resp_data cyc=%0d got=%h exp=%h", name, cyc, get_resp(), e);
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (!v[j] && $urandom_range(99) < p_valid) begin
                    v[j]    = 1'b1;
                    pend[j] = rand_req(j[0]);
                end
                drive_req(j, pend[j]);
            end
            req0_valid = v[0];
            req1_valid = v[1];
            resp_ready = ($urandom_range(99) < p_ready);
            #1;
            exp_rdy = 2'b00;
            if (!busy) begin
                if (v[0] && v[1]) exp_rdy = m_last ? 2'b01 : 2'b10;
                else              exp_rdy = {v[1], v[0]};
            end
            checks++;
            if ({req1_ready, req0_ready} !== exp_rdy) begin
                failures++;
                $display("FAIL %s_ready cyc=%0d got=%b exp=%b", name, cyc, {req1_ready, req0_ready}, exp_rdy);
            end
            if (busy && cyc - acc_cyc >= 2 && resp_ready) begin
                busy = 0;
                done++;
                exp_count++;
            end else if (!busy && exp_rdy != 2'b00) begin
                k       = exp_rdy[1] ? 1 : 0;
                cur     = pend[k];
                e       = expect_resp(cur);
                busy    = 1;
                acc_cyc = cyc;
                m_last  = k[0];
                v[k]    = 1'b0;
                if (check_alt) begin
                    checks++;
                    if (k != grants % 2) begin
                        failures++;
                        $display("FAIL %s_rr_order grant#%0d got=%0d exp=%0d", name, grants, k, grants % 2);
                    end
                end
                grants++;
            end
        end
        checks++;
        if (done < n_ops) begin
            failures++;
            $display("FAIL %s_timeout done=%0d exp=%0d", name, done, n_ops);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        test_traffic("round_robin", 4, 100, 100, 1'b1);
    endtask

    task automatic test_backpressure();
        req_t  q0, q1;
        resp_t e0, e1;
        q0 = '{id: 1'b0, a: 32'd5, b: 32'd5, op: 4'b0111, cin: 1'b0};
        q1 = '{id: 1'b1, a: 32'd3, b: 32'd4, op: 4'b0101, cin: 1'b1};
        e0 = {1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        e1 = {1'b1, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0};
        @(negedge clk);
        drive_req(0, q0); req0_valid = 1'b1; req1_valid = 1'b0; resp_ready = 1'b0; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_accept got=%b exp=01", {req1_ready, req0_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        drive_req(1, q1); req1_valid = 1'b1; #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || get_resp() !== e0 || {req1_ready, req0_ready} !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid=%b got=%h ready=%b exp valid=1 %h ready=00",
                         i, resp_valid, get_resp(), {req1_ready, req0_ready}, e0);
            end
        end
        resp_ready = 1'b1;
        exp_count++;
        @(negedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || op_count !== exp_count || {req1_ready, req0_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_release valid=%b cnt=%h ready=%b exp valid=0 cnt=%h ready=10",
                     resp_valid, op_count, {req1_ready, req0_ready}, exp_count);
        end
        m_last = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || get_resp() !== e1) begin
            failures++;
            $display("FAIL bp_second valid=%b got=%h exp=%h", resp_valid, get_resp(), e1);
        end
        exp_count++;
        @(negedge clk);
        checks++;
        if (op_count !== exp_count) begin
            failures++;
            $display("FAIL bp_count got=%h exp=%h", op_count, exp_count);
        end
    endtask

    task automatic test_illegal_op();
        req_t  q;
        resp_t e;
        q = '{id: 1'b1, a: $urandom, b: $urandom, op: 4'b1111, cin: 1'b1};
        e = {1'b1, 1'b1, 32'd0, 4'b0000};
        @(negedge clk);
        drive_req(1, q); req1_valid = 1'b1; resp_ready = 1'b1; #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            failures++;
            $display("FAIL illegal_accept got=%b exp=10", {req1_ready, req0_ready});
        end
        m_last = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || get_resp() !== e) begin
            failures++;
            $display("FAIL illegal_resp valid=%b got=%h exp=%h", resp_valid, get_resp(), e);
        end
        exp_count++;
        @(negedge clk);
        checks++;
        if (op_count !== exp_count) begin
            failures++;
            $display("FAIL illegal_count got=%h exp=%h", op_count, exp_count);
        end
    endtask

    task automatic test_reset_in_resp();
        req_t q;
        q = '{id: 1'b0, a: 32'h1234_5678, b: 32'h0000_1111, op: 4'b0101, cin: 1'b0};
        @(negedge clk);
        drive_req(0, q); req0_valid = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_resp_pre valid=%b exp=1", resp_valid);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (resp_valid !== 1'b0 || get_resp() !== 38'd0 || op_count !== 16'd0 ||
            {alu_a, alu_b, alu_cntrl, alu_cin} !== 69'd0) begin
            failures++;
            $display("FAIL rst_resp_async valid=%b resp=%h cnt=%h alu=%h exp all 0",
                     resp_valid, get_resp(), op_count, alu_a);
        end
        @(negedge clk);
        rst_n = 1'b1; m_last = 1'b1; exp_count = 16'd0; resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0 || op_count !== 16'd0) begin
                failures++;
                $display("FAIL rst_resp_ghost cyc=%0d valid=%b cnt=%h exp valid=0 cnt=0", i, resp_valid, op_count);
            end
        end
        test_traffic("post_reset", 2, 100, 100, 1'b1);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        exp_count = 16'hFFFF;
        #1;
        checks++;
        if (op_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload got=%h exp=ffff", op_count);
        end
        test_traffic("wrap", 1, 100, 100, 1'b0);
        checks++;
        if (op_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_result got=%h exp=0000", op_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_op = '0; req1_cin = 1'b0;
        m_last = 1'b1;
        exp_count = '0;
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_illegal_op();
        test_reset_in_resp();
        test_traffic("random", 40, 60, 50, 1'b0);
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
